// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execute stage with start/done handshake
// Single-cycle logic/arithmetic ops; shifts step one bit per clock.
module alu_exec_unit #(
   parameter int DATA_W  = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         alu_cnt,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  result,
   output logic               flag_s,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v,
   output logic               illegal
);
   localparam int MSB = DATA_W - 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state, state_d;
   logic [1:0]         shop_q, shop_d;
   logic [DATA_W-1:0]  work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]  res_q, res_d;
   logic               c_q, c_d, v_q, v_d, ill_q, ill_d;

   logic [DATA_W:0]    sum;
   logic [DATA_W-1:0]  op_res, sh_w;
   logic               op_c, op_v, op_ill, sh_c, is_shift;

   // Result of a request that completes in its accept cycle (incl. zero-length shifts)
   always_comb begin
      sum    = '0;
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      op_ill = 1'b0;
      case (alu_cnt)
         4'b0000: begin
            sum    = {1'b0, op_a} + {1'b0, op_b};
            op_res = sum[MSB:0];
            op_c   = sum[DATA_W];
            op_v   = (op_a[MSB] == op_b[MSB]) && (op_res[MSB] != op_a[MSB]);
         end
         4'b0001: begin
            op_res = op_a - op_b;
            op_c   = op_a < op_b;
            op_v   = (op_a[MSB] != op_b[MSB]) && (op_res[MSB] != op_a[MSB]);
         end
         4'b0010: op_res = op_a & op_b;
         4'b0011: op_res = op_a | op_b;
         4'b0100: op_res = op_a ^ op_b;
         4'b0110, 4'b1100, 4'b1101: op_res = op_b;
         4'b1000, 4'b1001, 4'b1010, 4'b1011: op_res = op_a;
         default: op_ill = 1'b1;
      endcase
   end

   always_comb begin
      sh_w = work_q;
      sh_c = 1'b0;
      case (shop_q)
         2'b00: begin sh_w = {work_q[MSB-1:0], 1'b0};       sh_c = work_q[MSB]; end
         2'b01: begin sh_w = {work_q[MSB-1:0], work_q[MSB]}; sh_c = work_q[MSB]; end
         2'b10: begin sh_w = {1'b0, work_q[MSB:1]};          sh_c = work_q[0];   end
         default: begin sh_w = {work_q[MSB], work_q[MSB:1]}; sh_c = work_q[0];   end
      endcase
   end

   assign is_shift = (alu_cnt[3:2] == 2'b10);

   always_comb begin
      state_d = state;
      shop_d  = shop_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      c_d     = c_q;
      v_d     = v_q;
      ill_d   = ill_q;
      case (state)
         IDLE: begin
            if (start) begin
               shop_d = alu_cnt[1:0];
               if (is_shift && (shamt != '0)) begin
                  work_d  = op_a;
                  cnt_d   = shamt;
                  state_d = SHIFT;
               end else begin
                  res_d   = op_res;
                  c_d     = op_c;
                  v_d     = op_v;
                  ill_d   = op_ill;
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            work_d = sh_w;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               res_d   = sh_w;
               c_d     = sh_c;
               v_d     = 1'b0;
               ill_d   = 1'b0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         shop_q <= '0;
         work_q <= '0;
         cnt_q  <= '0;
         res_q  <= '0;
         c_q    <= 1'b0;
         v_q    <= 1'b0;
         ill_q  <= 1'b0;
      end else begin
         state  <= state_d;
         shop_q <= shop_d;
         work_q <= work_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
         c_q    <= c_d;
         v_q    <= v_d;
         ill_q  <= ill_d;
      end
   end

   // Flags are zero after reset even though result is zero
   logic valid_q;
   always_ff @(posedge clk) begin
      if (!rst_n)               valid_q <= 1'b0;
      else if (state_d == DONE) valid_q <= 1'b1;
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign illegal = done & ill_q;
   assign result  = res_q;
   assign flag_s  = res_q[MSB];
   assign flag_z  = valid_q & (res_q == '0);
   assign flag_c  = c_q;
   assign flag_v  = v_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
// Directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_exec_unit;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    alu_cnt = '0;
   logic [W-1:0]  op_a = '0, op_b = '0;
   logic [3:0]    shamt = '0;
   logic          busy, done, flag_s, flag_z, flag_c, flag_v, illegal;
   logic [W-1:0]  result;

   int vecs = 0;
   int errs = 0;

   alu_exec_unit #(.DATA_W(W), .SHAMT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_cnt(alu_cnt),
      .op_a(op_a), .op_b(op_b), .shamt(shamt), .busy(busy), .done(done),
      .result(result), .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int n, output logic [W-1:0] r, output logic cf,
                                 output logic vf, output logic il, output int lat);
      int s;
      r = '0; cf = 1'b0; vf = 1'b0; il = 1'b0; lat = 0;
      case (c)
         4'd0: begin
            s  = int'(a) + int'(b);
            r  = s[W-1:0];
            cf = (s > 65535);
            vf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd1: begin
            r  = a - b;
            cf = (a < b);
            vf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd6, 4'd12, 4'd13: r = b;
         4'd8: begin r = a << n; cf = (n > 0) ? a[W-n] : 1'b0; lat = n; end
         4'd9: begin r = (a << n) | (a >> (W - n)); cf = (n > 0) ? r[0] : 1'b0; lat = n; end
         4'd10: begin r = a >> n; cf = (n > 0) ? a[n-1] : 1'b0; lat = n; end
         4'd11: begin r = W'($signed(a) >>> n); cf = (n > 0) ? a[n-1] : 1'b0; lat = n; end
         default: il = 1'b1;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
      logic [W-1:0] er;
      logic ec, ev, ei;
      int elat, k;
      model(c, a, b, n, er, ec, ev, ei, elat);
      @(negedge clk);
      start = 1'b1; alu_cnt = c; op_a = a; op_b = b; shamt = 4'(n);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("lat c=%0h n=%0d", c, n), k, elat);
      chk($sformatf("res c=%0h a=%h b=%h n=%0d", c, a, b, n), result, er);
      chk("flag_s", flag_s, er[W-1]);
      chk("flag_z", flag_z, (er == '0));
      chk($sformatf("flag_c c=%0h", c), flag_c, ec);
      chk($sformatf("flag_v c=%0h", c), flag_v, ev);
      chk("illegal", illegal, ei);
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
   endtask

   initial begin
      int nb, nd;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {flag_s, flag_z, flag_c, flag_v, illegal}, 0);
      rst_n = 1'b1;

      run_op(4'd0, 16'h7FFF, 16'h0001, 0);
      run_op(4'd1, 16'h0003, 16'h0005, 0);
      run_op(4'd1, 16'h1234, 16'h1234, 0);
      run_op(4'd11, 16'h8001, 16'h0000, 3);
      run_op(4'd9, 16'h8001, 16'h0000, 1);
      run_op(4'd8, 16'h5A5A, 16'h0000, 0);
      run_op(4'd7, 16'h1111, 16'h2222, 0);
      run_op(4'd6, 16'h0000, 16'hABCD, 0);
      run_op(4'd10, 16'hFFFF, 16'h0000, 15);

      // start held high through a 5-bit shift
      @(negedge clk);
      start = 1'b1; alu_cnt = 4'd8; op_a = 16'h00F1; op_b = '0; shamt = 4'd5;
      nb = 0; nd = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         nb += int'(busy);
         nd += int'(done);
      end
      chk("held_busy_cycles", nb, 6);
      chk("held_done_pulses", nd, 1);
      chk("held_result", result, 16'h1E20);
      chk("held_idle_gap", busy, 0);
      @(negedge clk);
      start = 1'b0;
      chk("held_second_accept", busy, 1);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("held_second_done", nd, 1);

      // reset in the middle of a long shift
      @(negedge clk);
      start = 1'b1; alu_cnt = 4'd8; op_a = 16'h0001; shamt = 4'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_flags", {flag_s, flag_z, flag_c, flag_v}, 0);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("midrst_no_done", nd, 0);
      run_op(4'd0, 16'hFFFF, 16'h0002, 0);

      for (int i = 0; i < 150; i++)
         run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
